nec_stack_pop_seq: RTL and testbench
====================================

Name: nec_stack_pop_seq

Overview:
Executes the `pop` bitmask from the decoded instruction record. The mask uses the same STACK_* bit encoding that the push side consumes. The block issues one 16-bit stack read per selected register, walking the mask in reverse push order (highest bit first), and returns each word as a one-hot register writeback. It sits between the execute stage and the bus interface unit, and serves RETI, POP R, POP sreg/mem and RET-class instructions.

Parameters:
ADDR_WIDTH, 20, physical address width; address = (ss<<4)+sp, truncated to ADDR_WIDTH.
SP_STEP, 2, bytes added to SP per consumed slot.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request, sampled only when busy=0
pop_mask  input  16  STACK_* pop mask, latched on start
sp_in  input  16  current SP, latched on start
ss_in  input  16  current SS, latched on start
busy  output  1  high from the cycle after an accepted start until the done cycle inclusive
mem_req  output  1  read request; held until acknowledged
mem_addr  output  ADDR_WIDTH  word address, stable while mem_req=1
mem_ack  input  1  read complete; mem_rdata valid in the same cycle
mem_rdata  input  16  read data
wr_en  output  1  one-cycle writeback strobe
wr_sel  output  16  one-hot STACK_* bit being written; 0 when wr_en=0
wr_data  output  16  popped word
sp_out  output  16  final SP; valid while done=1
done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset: FSM=IDLE; busy, mem_req, wr_en, done = 0; mem_addr, wr_sel, wr_data, sp_out = 0; the latched mask is cleared.
- Reset mid-operation: abandons the sequence immediately. mem_req drops the next cycle and no further writeback or done is produced. A mem_ack arriving during reset is ignored.
- States: IDLE, SELECT, READ, WB, DONE.
- IDLE:
  - start with mask≠0: latch mask, sp, ss; go SELECT.
  - start with mask=0: go DONE with sp_out=sp_in.
  - start while busy=1: ignored.
- SELECT: pick the highest set bit b of the remaining mask.
  - b=STACK_BP_SKIP_SP (0x0020): clear b, sp+=SP_STEP, no bus access, stay in SELECT (1 cycle per skip).
  - Otherwise: mem_req<=1, mem_addr<=((ss<<4)+sp) mod 2^ADDR_WIDTH; go READ.
- READ: wait any number of cycles for mem_ack.
  - On the ack cycle: mem_req<=0, wr_data<=mem_rdata, wr_sel<=b, wr_en<=1; go WB.
  - A mem_ack without mem_req is ignored.
- WB (wr_en=1 this cycle): clear b.
  - If b=STACK_SP (0x0010): sp<=wr_data (no increment).
  - Otherwise: sp<=sp+SP_STEP, mod 2^16, so 0xFFFE+2 wraps to 0x0000.
  - Remaining mask≠0: go SELECT. Otherwise: go DONE.
- DONE: done=1 and sp_out=sp for one cycle; next state IDLE, busy=0. A new start is accepted the cycle after done.
- Pop order equals reverse push order. Examples: PC→PS→PSW, and IY→IX→BP→(skip)→BW→DW→CW→AW.
- Timing: with mem_ack in the first mem_req cycle, each read costs 3 cycles (SELECT, READ, WB). Each skip costs 1 cycle, plus 1 DONE cycle.
- Byte alignment and odd-SP splitting are the BIU's responsibility.

Test Plan:
- RETI: pop_mask=0x4C00, sp_in=0x0100, ss_in=0x2000, zero-wait → reads at 0x20100/0x20102/0x20104 with wr_sel 0x4000, 0x0800, 0x0400 in that order; sp_out=0x0106; done 10 cycles after start.
- POP R: mask=0x01EF, sp_in=0x0FF0, ss_in=0 → 7 reads; wr_sel order 0x0100, 0x0080, 0x0040, 0x0008, 0x0004, 0x0002, 0x0001; no read at 0x00FF6; sp_out=0x1000.
- Wait states + wrap: mask=0x0001, sp_in=0xFFFE, ss_in=0xF000, mem_ack delayed 4 cycles → mem_req high 5 cycles, addr=0xFFFFE (stable); wr_data=mem_rdata; sp_out=0x0000.
- POP SP: mask=0x0010, sp_in=0x0200, rdata=0x1234 → wr_sel=0x0010; sp_out=0x1234.
- Empty mask and busy start: mask=0 → done the next cycle with sp_out=sp_in and no mem_req. A start pulsed mid-sequence → ignored; the mask is unchanged.
- Reset mid-READ: assert reset while mem_req=1 → all outputs 0 the next cycle; no wr_en or done afterwards; a late mem_ack is ignored.

Source files
------------

// File: rtl/nec_stack_pop_seq.sv
// Stack pop sequencer: walks a STACK_* pop mask from the highest bit down.
// It issues one 16-bit stack read per selected register and returns each word as a one-hot writeback.
module nec_stack_pop_seq #(
  parameter int ADDR_WIDTH = 20,
  parameter int SP_STEP    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           pop_mask,
  input  logic [15:0]           sp_in,
  input  logic [15:0]           ss_in,
  output logic                  busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic                  wr_en,
  output logic [15:0]           wr_sel,
  output logic [15:0]           wr_data,
  output logic [15:0]           sp_out,
  output logic                  done
);

  localparam logic [15:0] STACK_SP         = 16'h0010;
  localparam logic [15:0] STACK_BP_SKIP_SP = 16'h0020;
  localparam int          SUM_W            = (ADDR_WIDTH > 20) ? ADDR_WIDTH : 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_READ,
    S_WB,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           mask_q, mask_d;
  logic [15:0]           sp_q, sp_d;
  logic [15:0]           ss_q, ss_d;
  logic                  busy_q, busy_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [15:0]           wr_sel_q, wr_sel_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic [15:0]           sp_out_q, sp_out_d;
  logic                  done_q, done_d;

  logic [15:0]           top_bit;
  logic [15:0]           mask_cleared;
  logic [SUM_W-1:0]      lin_addr;

  // Highest set bit of the remaining mask; it stays put from SELECT through WB
  // because the mask only changes when that bit is retired.
  always_comb begin
    top_bit = '0;
    for (int i = 0; i < 16; i++) begin
      if (mask_q[i]) top_bit = 16'(1) << i;
    end
  end

  assign mask_cleared = mask_q & ~top_bit;
  assign lin_addr     = (SUM_W'(ss_q) << 4) + SUM_W'(sp_q);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a value unassigned (no latches).
    state_d    = state_q;
    mask_d     = mask_q;
    sp_d       = sp_q;
    ss_d       = ss_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wr_en_d    = 1'b0;
    wr_sel_d   = '0;
    wr_data_d  = wr_data_q;
    sp_out_d   = sp_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = pop_mask;
          sp_d   = sp_in;
          ss_d   = ss_in;
          if (pop_mask != '0) begin
            state_d = S_SELECT;
          end else begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            sp_out_d = sp_in;
          end
        end
      end

      S_SELECT: begin
        if (mask_q == '0) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          sp_out_d = sp_q;
        end else if (top_bit == STACK_BP_SKIP_SP) begin
          // The saved-SP slot is stepped over without a bus access.
          mask_d = mask_cleared;
          sp_d   = sp_q + 16'(SP_STEP);
          if (mask_cleared == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            sp_out_d = sp_d;
          end
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = lin_addr[ADDR_WIDTH-1:0];
          state_d    = S_READ;
        end
      end

      S_READ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          wr_data_d = mem_rdata;
          wr_sel_d  = top_bit;
          wr_en_d   = 1'b1;
          state_d   = S_WB;
        end
      end

      S_WB: begin
        mask_d = mask_cleared;
        sp_d   = (top_bit == STACK_SP) ? wr_data_q : sp_q + 16'(SP_STEP);
        if (mask_cleared != '0) begin
          state_d = S_SELECT;
        end else begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          sp_out_d = sp_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      sp_q       <= '0;
      ss_q       <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      sp_out_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      mask_q     <= mask_d;
      sp_q       <= sp_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_data_q  <= wr_data_d;
      sp_out_q   <= sp_out_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_sel   = wr_sel_q;
  assign wr_data  = wr_data_q;
  assign sp_out   = sp_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_nec_stack_pop_seq.sv
// Self-checking bench for nec_stack_pop_seq: directed test-plan cases plus random pop
// masks, wait states and stray starts/acks, checked against a mask-walking reference model.
module tb_nec_stack_pop_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pop_mask;
  logic [15:0] sp_in;
  logic [15:0] ss_in;
  logic        busy;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        wr_en;
  logic [15:0] wr_sel;
  logic [15:0] wr_data;
  logic [15:0] sp_out;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nec_stack_pop_seq #(.ADDR_WIDTH(20), .SP_STEP(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pop_mask  (pop_mask),
    .sp_in     (sp_in),
    .ss_in     (ss_in),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .sp_out    (sp_out),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one pop sequence. fixed_wait < 0 picks 0..3 wait cycles per read at random.
  task automatic run_op(input logic [15:0] mask, input logic [15:0] sp, input logic [15:0] ss,
                        input int fixed_wait, input bit use_data, input logic [15:0] data,
                        input bit poke_start,
                        output logic [15:0] sp_seen, output int cyc, output int req_cyc);
    logic [19:0] e_addr[$];
    logic [15:0] e_sel[$];
    logic [15:0] e_data[$];
    logic [15:0] m_sp;
    logic [19:0] cur_addr;
    int          skips, total_wait, n_rd, n_wb, waitcnt, exp_cyc;
    bit          in_req, seen_done, busy_ok, sel_ok, addr_ok;

    // Reference model: walk set bits from 15 down to 0.
    m_sp = sp;
    skips = 0;
    for (int b = 15; b >= 0; b--) begin
      if (mask[b]) begin
        logic [15:0] d;
        logic [15:0] one;
        logic [31:0] lin;
        if (b == 5) begin
          m_sp = m_sp + 16'd2;
          skips++;
        end else begin
          d   = use_data ? data : 16'($urandom);
          one = 16'd1 << b;
          lin = {12'd0, ss, 4'd0} + {16'd0, m_sp};
          e_addr.push_back(lin[19:0]);
          e_sel.push_back(one);
          e_data.push_back(d);
          m_sp = (b == 4) ? d : m_sp + 16'd2;
        end
      end
    end

    total_wait = 0; n_rd = 0; n_wb = 0; waitcnt = 0;
    in_req = 0; seen_done = 0; busy_ok = 1; sel_ok = 1; addr_ok = 1;
    cur_addr = '0; sp_seen = '0; cyc = 0; req_cyc = 0;

    @(negedge clk);
    start = 1'b1; pop_mask = mask; sp_in = sp; ss_in = ss;
    while (!seen_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      mem_ack = 1'b0;
      pop_mask = 16'($urandom);
      sp_in = 16'($urandom);
      ss_in = 16'($urandom);
      if (busy !== 1'b1) busy_ok = 0;
      if (wr_en !== 1'b1 && wr_sel !== 16'h0) sel_ok = 0;
      if (mem_req === 1'b1) begin
        req_cyc++;
        if (!in_req) begin
          in_req = 1;
          waitcnt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          total_wait += waitcnt;
          cur_addr = mem_addr;
          if (n_rd < e_addr.size()) check("rd_addr", mem_addr, e_addr[n_rd]);
          else check("rd_count_over", n_rd + 1, e_addr.size());
        end else if (mem_addr !== cur_addr) begin
          addr_ok = 0;
        end
        if (waitcnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = (n_rd < e_data.size()) ? e_data[n_rd] : 16'($urandom);
          n_rd++;
          in_req = 0;
        end else begin
          waitcnt--;
          mem_rdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray ack with no request outstanding must be ignored.
        mem_ack = 1'b1;
        mem_rdata = 16'($urandom);
      end
      if (wr_en === 1'b1) begin
        if (n_wb < e_sel.size()) begin
          check("wb_sel", wr_sel, e_sel[n_wb]);
          check("wb_data", wr_data, e_data[n_wb]);
        end else begin
          check("wb_count_over", n_wb + 1, e_sel.size());
        end
        n_wb++;
      end
      if (done === 1'b1) begin
        seen_done = 1;
        sp_seen = sp_out;
        check("sp_out", sp_out, m_sp);
      end else if (poke_start && busy === 1'b1 && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
      end
    end

    check("done_seen", seen_done, 1);
    check("read_count", n_rd, e_addr.size());
    check("wb_count", n_wb, e_sel.size());
    check("busy_during", busy_ok, 1);
    check("addr_stable", addr_ok, 1);
    check("wr_sel_idle_zero", sel_ok, 1);
    exp_cyc = (mask == 16'h0) ? 1 : 3 * e_addr.size() + skips + 1 + total_wait;
    check("latency", cyc, exp_cyc);

    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b0;
    check("idle_after", {28'd0, busy, done, mem_req, wr_en}, 32'd0);
  endtask

  logic [15:0] sp_seen;
  int          cyc, req_cyc;
  bit          bad;

  initial begin
    reset = 1'b1; start = 1'b0; pop_mask = '0; sp_in = '0; ss_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ctl", {28'd0, mem_req, wr_en, done, 1'b0}, 32'd0);
    check("rst_addr", mem_addr, 0);
    check("rst_sel", wr_sel, 0);
    check("rst_data", wr_data, 0);
    check("rst_sp_out", sp_out, 0);
    reset = 1'b0;
    @(negedge clk);

    // RETI, zero-wait
    run_op(16'h4C00, 16'h0100, 16'h2000, 0, 0, 16'h0, 0, sp_seen, cyc, req_cyc);
    check("reti_sp", sp_seen, 16'h0106);
    check("reti_cycles", cyc, 10);

    // POP R with BP skip slot
    run_op(16'h01EF, 16'h0FF0, 16'h0000, 0, 0, 16'h0, 0, sp_seen, cyc, req_cyc);
    check("popr_sp", sp_seen, 16'h1000);
    check("popr_req_cycles", req_cyc, 7);

    // Wait states + SP wrap
    run_op(16'h0001, 16'hFFFE, 16'hF000, 4, 0, 16'h0, 0, sp_seen, cyc, req_cyc);
    check("wrap_sp", sp_seen, 16'h0000);
    check("wrap_req_cycles", req_cyc, 5);

    // POP SP loads SP from the popped word
    run_op(16'h0010, 16'h0200, 16'h0000, 0, 1, 16'h1234, 0, sp_seen, cyc, req_cyc);
    check("popsp_sp", sp_seen, 16'h1234);

    // Empty mask
    run_op(16'h0000, 16'hABCD, 16'h1111, 0, 0, 16'h0, 0, sp_seen, cyc, req_cyc);
    check("empty_sp", sp_seen, 16'hABCD);
    check("empty_req", req_cyc, 0);

    // Skip-only mask, and starts pulsed mid-sequence
    run_op(16'h0020, 16'h0300, 16'h0000, 0, 0, 16'h0, 1, sp_seen, cyc, req_cyc);
    check("skip_only_sp", sp_seen, 16'h0302);
    run_op(16'hFFFF, 16'h1000, 16'h0400, -1, 0, 16'h0, 1, sp_seen, cyc, req_cyc);

    // Random sequences
    for (int n = 0; n < 60; n++) begin
      logic [15:0] m;
      m = 16'($urandom);
      if ($urandom_range(0, 2) == 0) m = m & 16'($urandom);
      if ($urandom_range(0, 12) == 0) m = 16'h0;
      run_op(m, 16'($urandom), 16'($urandom), -1, 0, 16'h0, bit'($urandom_range(0, 1)),
             sp_seen, cyc, req_cyc);
    end

    // Reset while a read is outstanding
    @(negedge clk);
    start = 1'b1; pop_mask = 16'h00C0; sp_in = 16'h0040; ss_in = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req === 1'b1) break;
      @(negedge clk);
    end
    check("rst_mid_req_seen", mem_req, 1);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_ctl", {28'd0, mem_req, wr_en, done, 1'b0}, 32'd0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_sel", wr_sel, 0);
    check("rstmid_data", wr_data, 0);
    check("rstmid_sp_out", sp_out, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ack = 1'(($urandom_range(0, 1)));
      mem_rdata = 16'($urandom);
      @(negedge clk);
      if (busy !== 1'b0 || mem_req !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) bad = 1;
    end
    mem_ack = 1'b0;
    check("rstmid_quiet", bad, 0);

    // Fresh operation after reset
    run_op(16'h4C00, 16'h0100, 16'h2000, -1, 0, 16'h0, 0, sp_seen, cyc, req_cyc);
    check("post_rst_sp", sp_seen, 16'h0106);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
